calib_sum: RTL and testbench

Streaming calibration-value accumulator for the Day 1 puzzle family. It consumes one ASCII character per accepted beat and extracts the first and last digit of each line. Each line contributes the two-digit value first*10 + last to a running sum. It generalises the original single-mode accumulator with a valid/ready handshake, explicit start/last framing, a parametrised sum width, per-line counting, error flags and an optional spelled-digit mode.

---
 rtl/calib_sum_pkg.sv | 39 +++
 rtl/calib_sum_word_match.sv | 41 ++++
 rtl/calib_sum.sv | 158 +++++++++++++++
 tb/tb_calib_sum.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/calib_sum_pkg.sv
// Shared types, ASCII constants and spelled-digit table for the calib_sum accumulator.
// The spelled-digit table is only consumed when CALIB_WORDS_EN is defined.
package calib_sum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HAVE = 2'd2,
        DONE = 2'd3
    } calib_state_t;

    localparam logic [7:0] CHAR_NL = 8'h0A;
    localparam logic [7:0] CHAR_0  = 8'h30;
    localparam logic [7:0] CHAR_9  = 8'h39;

    localparam int N_WORDS = 9;

    // Words are right-aligned in 40 bits so the newest char sits in the low byte.
    localparam logic [39:0] WORD_TXT [1:N_WORDS] = '{
        40'("one"), 40'("two"), 40'("three"), 40'("four"), 40'("five"),
        40'("six"), 40'("seven"), 40'("eight"), 40'("nine")
    };
    localparam int WORD_LEN [1:N_WORDS] = '{3, 3, 5, 4, 4, 3, 5, 5, 4};

    // Returns {hit, value} for a 5-char window ending in the current char.
    function automatic logic [4:0] word_match(input logic [39:0] win);
        logic [4:0]  res;
        logic [39:0] mask;
        res = '0;
        for (int w = 1; w <= N_WORDS; w++) begin
            mask = {40{1'b1}} >> (40 - 8 * WORD_LEN[w]);
            if ((win & mask) == WORD_TXT[w]) begin
                res = {1'b1, 4'(w)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/calib_sum_word_match.sv
// Spelled-digit matcher: 4-char history plus combinational match against the incoming char.
// Only instantiated when CALIB_WORDS_EN is defined.
module calib_word_match
    import calib_sum_pkg::*;
(
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       clear_i,
    input  logic       shift_i,
    input  logic [7:0] char_i,
    output logic       hit_o,
    output logic [3:0] value_o
);

    logic [31:0] hist_q;
    logic [31:0] hist_d;
    logic [4:0]  match;

    assign match   = word_match({hist_q, char_i});
    assign hit_o   = match[4];
    assign value_o = match[3:0];

    // Clear wins over shift so a closing char never leaks into the next line.
    always_comb begin
        hist_d = hist_q;
        if (clear_i) begin
            hist_d = '0;
        end else if (shift_i) begin
            hist_d = {hist_q[23:0], char_i};
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

endmodule

// File: rtl/calib_sum.sv
// Streaming calibration-value accumulator: first*10+last digit per line, summed over a framed stream.
// Define CALIB_WORDS_EN to also recognise spelled digits "one".."nine".
module calib_sum
    import calib_sum_pkg::*;
#(
    parameter int SUM_W  = 32,
    parameter int LINE_W = 16
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              start_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [7:0]        char_i,
    input  logic              last_i,
    output logic [SUM_W-1:0]  sum_o,
    output logic [LINE_W-1:0] lines_o,
    output logic              done_o,
    output logic              nodigit_o,
    output logic              ovf_o
);

    calib_state_t      state_q, state_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [LINE_W-1:0] lines_q, lines_d;
    logic              nodig_q, nodig_d;
    logic              ovf_q, ovf_d;
    logic [3:0]        first_q, first_d;
    logic [3:0]        last_q, last_d;

    logic       accept;
    logic       is_close;
    logic       dig_hit;
    logic [3:0] dig_val;
    logic [3:0] first_eff;
    logic [3:0] last_eff;
    logic       have_line;
    logic [6:0] line_val;
    logic [SUM_W:0] sum_ext;

    assign ready_o  = (state_q == SCAN) || (state_q == HAVE);
    assign accept   = valid_i && ready_o;
    assign is_close = (char_i == CHAR_NL) || last_i;

`ifdef CALIB_WORDS_EN
    logic       word_hit;
    logic [3:0] word_val;
    logic       hist_clr;

    assign hist_clr = (!ready_o && start_i) || (accept && is_close);

    calib_word_match u_word_match (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .clear_i (hist_clr),
        .shift_i (accept),
        .char_i  (char_i),
        .hit_o   (word_hit),
        .value_o (word_val)
    );

    always_comb begin
        dig_hit = 1'b0;
        dig_val = 4'd0;
        if (char_i >= CHAR_0 && char_i <= CHAR_9) begin
            dig_hit = 1'b1;
            dig_val = char_i[3:0];
        end else if (word_hit) begin
            dig_hit = 1'b1;
            dig_val = word_val;
        end
    end
`else
    // ASCII '0'..'9' are 0x30..0x39, so the low nibble is the digit value.
    assign dig_hit = (char_i >= CHAR_0) && (char_i <= CHAR_9);
    assign dig_val = char_i[3:0];
`endif

    // A closing char that is itself a digit must land in first/last before the sum.
    assign first_eff = (dig_hit && state_q == SCAN) ? dig_val : first_q;
    assign last_eff  = dig_hit ? dig_val : last_q;
    assign have_line = (state_q == HAVE) || dig_hit;
    assign line_val  = {first_eff, 3'b000} + {2'b00, first_eff, 1'b0} + {3'b000, last_eff};
    assign sum_ext   = {1'b0, sum_q} + {{(SUM_W - 6){1'b0}}, line_val};

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        lines_d = lines_q;
        nodig_d = nodig_q;
        ovf_d   = ovf_q;
        first_d = first_q;
        last_d  = last_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = SCAN;
                    sum_d   = '0;
                    lines_d = '0;
                    nodig_d = 1'b0;
                    ovf_d   = 1'b0;
                    first_d = '0;
                    last_d  = '0;
                end
            end
            SCAN, HAVE: begin
                if (accept) begin
                    if (is_close) begin
                        if (have_line) begin
                            sum_d = sum_ext[SUM_W-1:0];
                            ovf_d = ovf_q | sum_ext[SUM_W];
                        end else begin
                            nodig_d = 1'b1;
                        end
                        if (lines_q != '1) begin
                            lines_d = lines_q + 1'b1;
                        end
                        first_d = '0;
                        last_d  = '0;
                        state_d = last_i ? DONE : SCAN;
                    end else if (dig_hit) begin
                        first_d = first_eff;
                        last_d  = last_eff;
                        state_d = HAVE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            sum_q   <= '0;
            lines_q <= '0;
            nodig_q <= 1'b0;
            ovf_q   <= 1'b0;
            first_q <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            lines_q <= lines_d;
            nodig_q <= nodig_d;
            ovf_q   <= ovf_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign sum_o     = sum_q;
    assign lines_o   = lines_q;
    assign done_o    = (state_q == DONE);
    assign nodigit_o = nodig_q;
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_calib_sum.sv
// Self-checking bench for calib_sum: table-driven streams plus hand-written corner sequences.
module tb_calib_sum;

    logic        clk_i   = 1'b0;
    logic        rstn_i  = 1'b0;
    logic        start_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        last_i  = 1'b0;
    logic [7:0]  char_i  = 8'd0;

    logic        ready_o, done_o, nodigit_o, ovf_o;
    logic [31:0] sum_o;
    logic [15:0] lines_o;

    logic        ready8, done8, nodig8, ovf8;
    logic [7:0]  sum8;
    logic [15:0] lines8;

    int checks   = 0;
    int failures = 0;

    calib_sum #(.SUM_W(32), .LINE_W(16)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .valid_i(valid_i),
        .ready_o(ready_o), .char_i(char_i), .last_i(last_i), .sum_o(sum_o),
        .lines_o(lines_o), .done_o(done_o), .nodigit_o(nodigit_o), .ovf_o(ovf_o)
    );

    calib_sum #(.SUM_W(8), .LINE_W(16)) dut8 (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .valid_i(valid_i),
        .ready_o(ready8), .char_i(char_i), .last_i(last_i), .sum_o(sum8),
        .lines_o(lines8), .done_o(done8), .nodigit_o(nodig8), .ovf_o(ovf8)
    );

    always #5 clk_i = ~clk_i;

`ifdef CALIB_WORDS_EN
    localparam int WORD_SUM   = 281;
    localparam bit WORD_NODIG = 1'b0;
`else
    localparam int WORD_SUM   = 209;
    localparam bit WORD_NODIG = 1'b1;
`endif

    typedef struct {
        int sum;
        int lines;
        bit nodig;
        bit gappy;
    } exp_t;

    localparam int NV = 5;
    string txt [NV];
    exp_t  tab [NV];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    // Drives one char per beat at negedge; last_i marks the final char when fin is set.
    task automatic send(input string s, input bit gappy, input bit fin);
        for (int i = 0; i < s.len(); i++) begin
            if (gappy) begin
                for (int g = 0; g < 3 && $urandom_range(1, 0) == 0; g++) begin
                    valid_i = 1'b0;
                    @(negedge clk_i);
                end
            end
            char_i  = s[i];
            last_i  = fin && (i == s.len() - 1);
            valid_i = 1'b1;
            chk("ready_in_stream", ready_o, 1);
            @(negedge clk_i);
        end
        valid_i = 1'b0;
        last_i  = 1'b0;
        char_i  = 8'd0;
    endtask

    initial begin
        txt[0] = "1abc2\npqr3stu8vwx\na1b2c3d4e5f\ntreb7uchet";
        tab[0] = '{sum: 142, lines: 4, nodig: 1'b0, gappy: 1'b0};
        txt[1] = "two1nine\neightwothree\nabcone2threexyz\nxtwone3four\n4nineeightseven2\nzoneight234\n7pqrstsixteen";
        tab[1] = '{sum: WORD_SUM, lines: 7, nodig: WORD_NODIG, gappy: 1'b0};
        txt[2] = "91\n5";
        tab[2] = '{sum: 146, lines: 2, nodig: 1'b0, gappy: 1'b1};
        txt[3] = "91\n5";
        tab[3] = '{sum: 146, lines: 2, nodig: 1'b0, gappy: 1'b0};
        txt[4] = "abc\n7";
        tab[4] = '{sum: 77, lines: 2, nodig: 1'b1, gappy: 1'b0};

        repeat (2) @(negedge clk_i);
        chk("rst_sum", sum_o, 0);
        chk("rst_lines", lines_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_nodig", nodigit_o, 0);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_ready", ready_o, 0);
        rstn_i = 1'b1;
        @(negedge clk_i);
        chk("idle_ready", ready_o, 0);

        for (int v = 0; v < NV; v++) begin
            do_start();
            chk($sformatf("v%0d_ready_after_start", v), ready_o, 1);
            chk($sformatf("v%0d_sum_cleared", v), sum_o, 0);
            send(txt[v], tab[v].gappy, 1'b1);
            chk($sformatf("v%0d_sum", v), sum_o, tab[v].sum);
            chk($sformatf("v%0d_lines", v), lines_o, tab[v].lines);
            chk($sformatf("v%0d_done", v), done_o, 1);
            chk($sformatf("v%0d_ready_low", v), ready_o, 0);
            chk($sformatf("v%0d_nodig", v), nodigit_o, tab[v].nodig);
        end

        // DONE holds, then start in DONE clears everything the next cycle.
        repeat (3) @(negedge clk_i);
        chk("done_hold_sum", sum_o, 77);
        chk("done_hold_done", done_o, 1);
        do_start();
        chk("restart_sum", sum_o, 0);
        chk("restart_lines", lines_o, 0);
        chk("restart_nodig", nodigit_o, 0);
        chk("restart_done", done_o, 0);
        chk("restart_ready", ready_o, 1);

        // start_i inside a stream is ignored.
        send("5\n", 1'b0, 1'b0);
        chk("scan_sum_before", sum_o, 55);
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("scan_start_sum", sum_o, 55);
        chk("scan_start_lines", lines_o, 1);
        chk("scan_start_ready", ready_o, 1);
        send("3", 1'b0, 1'b1);
        chk("scan_start_final", sum_o, 88);
        chk("scan_start_final_lines", lines_o, 2);

        // Wrap on the 8-bit instance, none on the 32-bit one.
        do_start();
        send("99\n99\n99", 1'b0, 1'b1);
        chk("ovf8_sum", sum8, 41);
        chk("ovf8_flag", ovf8, 1);
        chk("ovf8_lines", lines8, 3);
        chk("ovf32_sum", sum_o, 297);
        chk("ovf32_flag", ovf_o, 0);

        // Asynchronous reset mid-line.
        do_start();
        send("5\n7x", 1'b0, 1'b0);
        chk("pre_rst_sum", sum_o, 55);
        rstn_i = 1'b0;
        #1;
        chk("async_rst_sum", sum_o, 0);
        chk("async_rst_lines", lines_o, 0);
        chk("async_rst_ready", ready_o, 0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        do_start();
        send("12", 1'b0, 1'b1);
        chk("post_rst_sum", sum_o, 12);
        chk("post_rst_lines", lines_o, 1);
        chk("post_rst_done", done_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
